// File: rtl/pong_pkg.sv
// Shared types and constants for the pong direction/scoring controller.
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StScored,
    StGameOver
  } state_e;

  localparam logic [1:0] DIR_POS  = 2'b10;
  localparam logic [1:0] DIR_NEG  = 2'b01;
  localparam logic [1:0] DIR_NONE = 2'b00;

  localparam int unsigned DefScreenW  = 640;
  localparam int unsigned DefScreenH  = 480;
  localparam int unsigned DefBallSize = 8;
  localparam int unsigned DefPaddleW  = 8;
  localparam int unsigned DefPaddleH  = 64;
  localparam int unsigned DefPaddleLX = 16;
  localparam int unsigned DefPaddleRX = 616;
  localparam int unsigned DefWinScore = 7;

  // Score increment that never passes the winning total.
  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? max : val + 4'd1;
  endfunction

endpackage

// File: rtl/pong_dir_ctrl_if.sv
// Ball/paddle status in, direction/score/status out, between game logic and the controller.
interface pong_dir_ctrl_if;

  logic       pause;
  logic       ball_step;
  logic       serve;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [1:0] x_dir;
  logic [1:0] y_dir;
  logic       ball_reload;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  modport master (
    output pause, ball_step, serve, x_pos, y_pos, pad_l_y, pad_r_y,
    input  x_dir, y_dir, ball_reload, score_l, score_r, game_over
  );

  modport slave (
    input  pause, ball_step, serve, x_pos, y_pos, pad_l_y, pad_r_y,
    output x_dir, y_dir, ball_reload, score_l, score_r, game_over
  );

endinterface

// File: rtl/pong_hit_detect.sv
// Combinational paddle contact test: vertical overlap and ball edge at the paddle face.
module pong_hit_detect
  import pong_pkg::*;
#(
  parameter int unsigned BallSize   = DefBallSize,
  parameter int unsigned PaddleH    = DefPaddleH,
  // 0 compares the ball's left edge, BallSize compares its right edge
  parameter int unsigned EdgeOffset = 0
) (
  input  logic [9:0]  x_pos_i,
  input  logic [9:0]  y_pos_i,
  input  logic [9:0]  pad_y_i,
  input  logic [10:0] face_x_i,
  output logic        overlap_o,
  output logic        face_hit_o
);

  logic [10:0] ball_top;
  logic [10:0] ball_bot;
  logic [10:0] pad_top;
  logic [10:0] pad_bot;
  logic [10:0] ball_edge;

  always_comb begin
    ball_top  = {1'b0, y_pos_i};
    ball_bot  = {1'b0, y_pos_i} + 11'(BallSize);
    pad_top   = {1'b0, pad_y_i};
    pad_bot   = {1'b0, pad_y_i} + 11'(PaddleH);
    ball_edge = {1'b0, x_pos_i} + 11'(EdgeOffset);

    overlap_o  = (ball_bot > pad_top) && (ball_top < pad_bot);
    face_hit_o = (ball_edge == face_x_i);
  end

endmodule

// File: rtl/pong_dir_ctrl.sv
// Ball direction, bounce, miss and score controller feeding the ball position stage.
module pong_dir_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W   = DefScreenW,
  parameter int unsigned SCREEN_H   = DefScreenH,
  parameter int unsigned BALL_SIZE  = DefBallSize,
  parameter int unsigned PADDLE_W   = DefPaddleW,
  parameter int unsigned PADDLE_H   = DefPaddleH,
  parameter int unsigned PADDLE_L_X = DefPaddleLX,
  parameter int unsigned PADDLE_R_X = DefPaddleRX,
  parameter int unsigned WIN_SCORE  = DefWinScore
) (
  input logic             clk,
  input logic             reset,
  pong_dir_ctrl_if.slave  ctrl_io
);

  localparam logic [10:0] LFaceX   = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [10:0] RFaceX   = 11'(PADDLE_R_X);
  localparam logic [3:0]  WinScore = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [1:0] x_dir_q, x_dir_d;
  logic [1:0] y_dir_q, y_dir_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       ball_reload_q, ball_reload_d;
  logic       game_over_q, game_over_d;
  logic       serve_right_q, serve_right_d;
  logic       y_toggle_q, y_toggle_d;

  logic overlap_l, face_l;
  logic overlap_r, face_r;

  pong_hit_detect #(
    .BallSize   (BALL_SIZE),
    .PaddleH    (PADDLE_H),
    .EdgeOffset (0)
  ) u_hit_l (
    .x_pos_i    (ctrl_io.x_pos),
    .y_pos_i    (ctrl_io.y_pos),
    .pad_y_i    (ctrl_io.pad_l_y),
    .face_x_i   (LFaceX),
    .overlap_o  (overlap_l),
    .face_hit_o (face_l)
  );

  pong_hit_detect #(
    .BallSize   (BALL_SIZE),
    .PaddleH    (PADDLE_H),
    .EdgeOffset (BALL_SIZE)
  ) u_hit_r (
    .x_pos_i    (ctrl_io.x_pos),
    .y_pos_i    (ctrl_io.y_pos),
    .pad_y_i    (ctrl_io.pad_r_y),
    .face_x_i   (RFaceX),
    .overlap_o  (overlap_r),
    .face_hit_o (face_r)
  );

  logic step_en, serve_en;
  logic miss_l, miss_r;
  logic wall_top, wall_bot;
  logic hit_l, hit_r;
  logic win_reached;

  always_comb begin
    step_en  = ctrl_io.ball_step & ~ctrl_io.pause;
    serve_en = ctrl_io.serve & ~ctrl_io.pause;

    miss_l   = (x_dir_q == DIR_NEG) && (ctrl_io.x_pos == 10'd0);
    miss_r   = (x_dir_q == DIR_POS) &&
               (({1'b0, ctrl_io.x_pos} + 11'(BALL_SIZE)) >= 11'(SCREEN_W));
    wall_top = (y_dir_q == DIR_NEG) && (ctrl_io.y_pos == 10'd0);
    wall_bot = (y_dir_q == DIR_POS) &&
               (({1'b0, ctrl_io.y_pos} + 11'(BALL_SIZE)) >= 11'(SCREEN_H));
    hit_l    = (x_dir_q == DIR_NEG) && face_l && overlap_l;
    hit_r    = (x_dir_q == DIR_POS) && face_r && overlap_r;

    win_reached = (score_l_q == WinScore) || (score_r_q == WinScore);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (serve_en) state_d = StPlay;
      end
      StPlay: begin
        if (step_en && (miss_l || miss_r)) state_d = StScored;
      end
      StScored: begin
        if (!ctrl_io.pause) state_d = win_reached ? StGameOver : StIdle;
      end
      StGameOver: begin
        state_d = StGameOver;
      end
    endcase
  end

  // Output and datapath next values; everything holds by default so pause freezes it all.
  always_comb begin
    x_dir_d       = x_dir_q;
    y_dir_d       = y_dir_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    ball_reload_d = 1'b0;
    game_over_d   = game_over_q;
    serve_right_d = serve_right_q;
    y_toggle_d    = y_toggle_q;

    unique case (state_q)
      StIdle: begin
        x_dir_d = DIR_NONE;
        y_dir_d = DIR_NONE;
        if (serve_en) begin
          x_dir_d    = serve_right_q ? DIR_POS : DIR_NEG;
          y_dir_d    = y_toggle_q ? DIR_NEG : DIR_POS;
          y_toggle_d = ~y_toggle_q;
        end
      end
      StPlay: begin
        if (step_en) begin
          if (miss_l) begin
            score_r_d     = sat_inc(score_r_q, WinScore);
            serve_right_d = 1'b0;
            ball_reload_d = 1'b1;
            x_dir_d       = DIR_NONE;
            y_dir_d       = DIR_NONE;
          end else if (miss_r) begin
            score_l_d     = sat_inc(score_l_q, WinScore);
            serve_right_d = 1'b1;
            ball_reload_d = 1'b1;
            x_dir_d       = DIR_NONE;
            y_dir_d       = DIR_NONE;
          end else begin
            // Wall and paddle flips are independent so a corner hit flips both axes.
            if (wall_top) y_dir_d = DIR_POS;
            else if (wall_bot) y_dir_d = DIR_NEG;
            if (hit_l) x_dir_d = DIR_POS;
            else if (hit_r) x_dir_d = DIR_NEG;
          end
        end
      end
      StScored: begin
        x_dir_d = DIR_NONE;
        y_dir_d = DIR_NONE;
        if (!ctrl_io.pause && win_reached) game_over_d = 1'b1;
      end
      StGameOver: begin
        x_dir_d     = DIR_NONE;
        y_dir_d     = DIR_NONE;
        game_over_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_dir_q       <= DIR_NONE;
      y_dir_q       <= DIR_NONE;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      ball_reload_q <= 1'b0;
      game_over_q   <= 1'b0;
      serve_right_q <= 1'b1;
      y_toggle_q    <= 1'b0;
    end else begin
      x_dir_q       <= x_dir_d;
      y_dir_q       <= y_dir_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      ball_reload_q <= ball_reload_d;
      game_over_q   <= game_over_d;
      serve_right_q <= serve_right_d;
      y_toggle_q    <= y_toggle_d;
    end
  end

  assign ctrl_io.x_dir       = x_dir_q;
  assign ctrl_io.y_dir       = y_dir_q;
  assign ctrl_io.score_l     = score_l_q;
  assign ctrl_io.score_r     = score_r_q;
  assign ctrl_io.ball_reload = ball_reload_q;
  assign ctrl_io.game_over   = game_over_q;

endmodule

// File: tb/tb_pong_dir_ctrl.sv
// Directed-vector bench for pong_dir_ctrl with hand-computed expectations.
module tb_pong_dir_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pong_dir_ctrl_if bus ();

  pong_dir_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_io (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle for spacing, then a single-cycle ball_step at the given position.
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    cyc();
    bus.x_pos     = x;
    bus.y_pos     = y;
    bus.ball_step = 1'b1;
    cyc();
    bus.ball_step = 1'b0;
  endtask

  task automatic do_serve();
    bus.serve = 1'b1;
    cyc();
    bus.serve = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.pause     = 1'b0;
    bus.ball_step = 1'b0;
    bus.serve     = 1'b0;
    bus.x_pos     = 10'd300;
    bus.y_pos     = 10'd200;
    bus.pad_l_y   = 10'd300;
    bus.pad_r_y   = 10'd300;

    #2;
    check_eq("rst_x_dir", 32'(bus.x_dir), 0);
    check_eq("rst_y_dir", 32'(bus.y_dir), 0);
    check_eq("rst_score_l", 32'(bus.score_l), 0);
    check_eq("rst_score_r", 32'(bus.score_r), 0);
    check_eq("rst_reload", 32'(bus.ball_reload), 0);
    check_eq("rst_game_over", 32'(bus.game_over), 0);
    cyc();
    reset = 1'b0;
    cyc();

    do_serve();
    check_eq("serve1_x", 32'(bus.x_dir), 2);
    check_eq("serve1_y", 32'(bus.y_dir), 2);

    step(10'd300, 10'd472);
    check_eq("bottom_wall_y", 32'(bus.y_dir), 1);
    check_eq("bottom_wall_x", 32'(bus.x_dir), 2);
    step(10'd300, 10'd0);
    check_eq("top_wall_y", 32'(bus.y_dir), 2);
    step(10'd300, 10'd472);
    check_eq("bottom_wall2_y", 32'(bus.y_dir), 1);

    bus.pad_r_y = 10'd180;
    step(10'd608, 10'd200);
    check_eq("rpad_hit_x", 32'(bus.x_dir), 1);

    bus.pad_l_y = 10'd100;
    step(10'd24, 10'd92);
    check_eq("lpad_y92_x", 32'(bus.x_dir), 1);
    step(10'd24, 10'd164);
    check_eq("lpad_y164_x", 32'(bus.x_dir), 1);
    step(10'd24, 10'd93);
    check_eq("lpad_y93_x", 32'(bus.x_dir), 2);
    step(10'd608, 10'd200);
    check_eq("rpad_hit2_x", 32'(bus.x_dir), 1);
    step(10'd24, 10'd163);
    check_eq("lpad_y163_x", 32'(bus.x_dir), 2);

    step(10'd632, 10'd200);
    check_eq("rmiss_score_l", 32'(bus.score_l), 1);
    check_eq("rmiss_score_r", 32'(bus.score_r), 0);
    check_eq("rmiss_reload", 32'(bus.ball_reload), 1);
    check_eq("rmiss_x", 32'(bus.x_dir), 0);
    check_eq("rmiss_y", 32'(bus.y_dir), 0);
    cyc();
    check_eq("reload_pulse_end", 32'(bus.ball_reload), 0);
    check_eq("no_game_over", 32'(bus.game_over), 0);

    do_serve();
    check_eq("serve2_x", 32'(bus.x_dir), 2);
    check_eq("serve2_y", 32'(bus.y_dir), 1);

    step(10'd608, 10'd200);
    check_eq("rpad_hit3_x", 32'(bus.x_dir), 1);
    bus.pad_l_y = 10'd0;
    step(10'd24, 10'd0);
    check_eq("corner_x", 32'(bus.x_dir), 2);
    check_eq("corner_y", 32'(bus.y_dir), 2);

    bus.pause = 1'b1;
    step(10'd632, 10'd200);
    check_eq("pause_x", 32'(bus.x_dir), 2);
    check_eq("pause_score_l", 32'(bus.score_l), 1);
    check_eq("pause_reload", 32'(bus.ball_reload), 0);
    bus.pause = 1'b0;
    step(10'd608, 10'd200);
    check_eq("after_pause_x", 32'(bus.x_dir), 1);

    for (int i = 1; i <= 7; i++) begin
      if (i > 1) begin
        cyc();
        do_serve();
        check_eq("serve_left_x", 32'(bus.x_dir), 1);
      end
      step(10'd0, 10'd200);
      check_eq("lmiss_score_r", 32'(bus.score_r), 32'(i));
      check_eq("lmiss_reload", 32'(bus.ball_reload), 1);
    end
    cyc();
    check_eq("game_over_set", 32'(bus.game_over), 1);
    check_eq("game_over_reload", 32'(bus.ball_reload), 0);

    do_serve();
    check_eq("go_serve_x", 32'(bus.x_dir), 0);
    check_eq("go_serve_y", 32'(bus.y_dir), 0);
    check_eq("go_hold", 32'(bus.game_over), 1);
    check_eq("go_score_r", 32'(bus.score_r), 7);
    check_eq("go_score_l", 32'(bus.score_l), 1);

    reset = 1'b1;
    #1;
    check_eq("reset_go_clear", 32'(bus.game_over), 0);
    check_eq("reset_score_r", 32'(bus.score_r), 0);
    cyc();
    reset = 1'b0;
    cyc();

    do_serve();
    check_eq("serve3_x", 32'(bus.x_dir), 2);
    check_eq("serve3_y", 32'(bus.y_dir), 2);
    reset = 1'b1;
    #1;
    check_eq("async_rst_x", 32'(bus.x_dir), 0);
    check_eq("async_rst_y", 32'(bus.y_dir), 0);
    cyc();
    reset = 1'b0;
    cyc();
    check_eq("idle_after_rst_x", 32'(bus.x_dir), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
